// File: rtl/mod_n_updown_counter.sv
// Cascadable modulo-N up/down counter with lookahead carry/borrow, wrap or saturate policy.
// Define MOD_N_COUNTER_BCD_EN to add a registered BCD shadow of count (requires MODULUS <= 100).
module mod_n_updown_counter #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             at_max,
    output logic             at_min,
    output logic             load_err,
    output logic [7:0]       count_bcd
);

    // MODULUS-1 always fits in WIDTH bits, so no compare needs an extra bit
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);
    localparam bit               WRAP_EN = (WRAP != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             load_err_q, load_err_d;
    logic             load_clamp;

    assign at_max     = (count_q == MAX_V);
    assign at_min     = (count_q == '0);
    assign load_clamp = (load_value > MAX_V);

    assign carry_out  = WRAP_EN && enable &&  dir && at_max && !clear && !load;
    assign borrow_out = WRAP_EN && enable && !dir && at_min && !clear && !load;

    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d    = load_clamp ? MAX_V : load_value;
            load_err_d = load_clamp;
        end else if (enable) begin
            if (dir) begin
                if (at_max) count_d = WRAP_EN ? '0 : count_q;
                else        count_d = count_q + WIDTH'(1);
            end else begin
                if (at_min) count_d = WRAP_EN ? MAX_V : count_q;
                else        count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign load_err = load_err_q;

`ifdef MOD_N_COUNTER_BCD_EN
    if (MODULUS > 100) begin : g_bcd_range_err
        $error("mod_n_updown_counter: BCD shadow needs MODULUS <= 100");
    end

    localparam logic [7:0] MAX_BCD = 8'((((MODULUS - 1) / 10) * 16) + ((MODULUS - 1) % 10));

    // Compare ladder for the load path; avoids a divider on the preset value
    function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
        logic [31:0] vw;
        logic [3:0]  tens;
        vw   = 32'(v);
        tens = 4'd0;
        for (int t = 1; t < 10; t++)
            if (vw >= 32'(t * 10)) tens = 4'(t);
        return {tens, 4'(vw - 32'(tens) * 32'd10)};
    endfunction

    logic [7:0] bcd_q, bcd_d, bcd_inc, bcd_dec;

    always_comb begin
        bcd_inc = (bcd_q[3:0] == 4'd9) ? {bcd_q[7:4] + 4'd1, 4'd0}
                                       : {bcd_q[7:4], bcd_q[3:0] + 4'd1};
        bcd_dec = (bcd_q[3:0] == 4'd0) ? {bcd_q[7:4] - 4'd1, 4'd9}
                                       : {bcd_q[7:4], bcd_q[3:0] - 4'd1};
        bcd_d = bcd_q;
        if (clear) begin
            bcd_d = 8'h00;
        end else if (load) begin
            bcd_d = load_clamp ? MAX_BCD : to_bcd(load_value);
        end else if (enable) begin
            if (dir) begin
                if (at_max) bcd_d = WRAP_EN ? 8'h00 : bcd_q;
                else        bcd_d = bcd_inc;
            end else begin
                if (at_min) bcd_d = WRAP_EN ? MAX_BCD : bcd_q;
                else        bcd_d = bcd_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcd_q <= 8'h00;
        else        bcd_q <= bcd_d;
    end

    assign count_bcd = bcd_q;
`else
    assign count_bcd = 8'h00;
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Randomised and directed bench: seconds->minutes chain, a saturating stage and a 2^WIDTH stage.
module tb_mod_n_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, ld, en, dir, min_ld;
    logic [5:0] lv, min_lv;

    logic [5:0] sec_cnt, min_cnt, sat_cnt;
    logic [3:0] p2_cnt;
    logic       sec_co, sec_bo, sec_mx, sec_mn, sec_le;
    logic       min_co, min_bo, min_mx, min_mn, min_le;
    logic       sat_co, sat_bo, sat_mx, sat_mn, sat_le;
    logic       p2_co, p2_bo, p2_mx, p2_mn, p2_le;
    logic [7:0] sec_bcd, min_bcd, sat_bcd, p2_bcd;

    int total = 0;
    int bad   = 0;
    int m_sec, m_min, m_sat, m_p2;
    bit e_sec, e_min, e_sat, e_p2;

    always #5 clk = ~clk;

    mod_n_updown_counter #(.MODULUS(60), .WIDTH(6), .WRAP(1)) u_sec (
        .clk(clk), .rst_n(rst_n), .enable(en), .clear(clr), .load(ld), .load_value(lv),
        .dir(dir), .count(sec_cnt), .carry_out(sec_co), .borrow_out(sec_bo),
        .at_max(sec_mx), .at_min(sec_mn), .load_err(sec_le), .count_bcd(sec_bcd));

    mod_n_updown_counter #(.MODULUS(60), .WIDTH(6), .WRAP(1)) u_min (
        .clk(clk), .rst_n(rst_n), .enable(sec_co | sec_bo), .clear(clr), .load(min_ld),
        .load_value(min_lv), .dir(dir), .count(min_cnt), .carry_out(min_co),
        .borrow_out(min_bo), .at_max(min_mx), .at_min(min_mn), .load_err(min_le),
        .count_bcd(min_bcd));

    mod_n_updown_counter #(.MODULUS(60), .WIDTH(6), .WRAP(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(en), .clear(clr), .load(ld), .load_value(lv),
        .dir(dir), .count(sat_cnt), .carry_out(sat_co), .borrow_out(sat_bo),
        .at_max(sat_mx), .at_min(sat_mn), .load_err(sat_le), .count_bcd(sat_bcd));

    mod_n_updown_counter #(.MODULUS(16), .WIDTH(4), .WRAP(1)) u_p2 (
        .clk(clk), .rst_n(rst_n), .enable(en), .clear(clr), .load(ld), .load_value(lv[3:0]),
        .dir(dir), .count(p2_cnt), .carry_out(p2_co), .borrow_out(p2_bo),
        .at_max(p2_mx), .at_min(p2_mn), .load_err(p2_le), .count_bcd(p2_bcd));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    function automatic int bcd(input int v);
`ifdef MOD_N_COUNTER_BCD_EN
        return (v / 10) * 16 + (v % 10);
`else
        return 0 * v;
`endif
    endfunction

    function automatic int nxt(input int c, input int m, input bit w, input bit c_clr,
                               input bit c_ld, input int c_lv, input bit c_en, input bit d);
        if (c_clr) return 0;
        if (c_ld)  return (c_lv > m - 1) ? m - 1 : c_lv;
        if (!c_en) return c;
        if (d) return w ? (c + 1) % m : ((c + 1 < m) ? c + 1 : c);
        return w ? (c + m - 1) % m : ((c > 0) ? c - 1 : 0);
    endfunction

    function automatic bit err(input int m, input bit c_clr, input bit c_ld, input int c_lv);
        return !c_clr && c_ld && (c_lv > m - 1);
    endfunction

    task automatic chk_flags(input string n, input int c, input int m, input bit w,
                             input bit c_en, input bit c_ld,
                             input logic co, input logic bo, input logic mx, input logic mn);
        chk({n, "_carry"},  int'(co), int'(w && c_en &&  dir && c == m - 1 && !clr && !c_ld));
        chk({n, "_borrow"}, int'(bo), int'(w && c_en && !dir && c == 0     && !clr && !c_ld));
        chk({n, "_at_max"}, int'(mx), int'(c == m - 1));
        chk({n, "_at_min"}, int'(mn), int'(c == 0));
    endtask

    // Inputs are already set; check lookahead outputs, clock once, check registered state
    task automatic step();
        bit men;
        #1;
        men = (en && dir && m_sec == 59 && !clr && !ld) || (en && !dir && m_sec == 0 && !clr && !ld);
        chk_flags("sec", m_sec, 60, 1'b1, en,  ld,     sec_co, sec_bo, sec_mx, sec_mn);
        chk_flags("min", m_min, 60, 1'b1, men, min_ld, min_co, min_bo, min_mx, min_mn);
        chk_flags("sat", m_sat, 60, 1'b0, en,  ld,     sat_co, sat_bo, sat_mx, sat_mn);
        chk_flags("p2",  m_p2,  16, 1'b1, en,  ld,     p2_co,  p2_bo,  p2_mx,  p2_mn);
        e_sec = err(60, clr, ld, int'(lv));
        e_min = err(60, clr, min_ld, int'(min_lv));
        e_sat = err(60, clr, ld, int'(lv));
        e_p2  = err(16, clr, ld, int'(lv[3:0]));
        m_sec = nxt(m_sec, 60, 1'b1, clr, ld, int'(lv), en, dir);
        m_min = nxt(m_min, 60, 1'b1, clr, min_ld, int'(min_lv), men, dir);
        m_sat = nxt(m_sat, 60, 1'b0, clr, ld, int'(lv), en, dir);
        m_p2  = nxt(m_p2,  16, 1'b1, clr, ld, int'(lv[3:0]), en, dir);
        @(posedge clk);
        #1;
        chk("sec_cnt", int'(sec_cnt), m_sec);
        chk("min_cnt", int'(min_cnt), m_min);
        chk("sat_cnt", int'(sat_cnt), m_sat);
        chk("p2_cnt",  int'(p2_cnt),  m_p2);
        chk("sec_err", int'(sec_le), int'(e_sec));
        chk("min_err", int'(min_le), int'(e_min));
        chk("sat_err", int'(sat_le), int'(e_sat));
        chk("p2_err",  int'(p2_le),  int'(e_p2));
        chk("sec_bcd", int'(sec_bcd), bcd(m_sec));
        chk("p2_bcd",  int'(p2_bcd),  bcd(m_p2));
    endtask

    task automatic set_in(input bit c, input bit l, input int v, input bit e, input bit d);
        clr = c; ld = l; lv = 6'(v); en = e; dir = d; min_ld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 1);
        min_lv = '0;
        m_sec = 0; m_min = 0; m_sat = 0; m_p2 = 0;
        #12;
        chk("rst_cnt",    int'(sec_cnt), 0);
        chk("rst_at_min", int'(sec_mn), 1);
        chk("rst_at_max", int'(sec_mx), 0);
        chk("rst_carry",  int'(sec_co), 0);
        chk("rst_borrow", int'(sec_bo), 0);
        chk("rst_err",    int'(sec_le), 0);
        chk("rst_bcd",    int'(sec_bcd), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // free-running seconds: 0..59 then back to 0
        set_in(0, 0, 0, 1, 1);
        repeat (60) step();
        chk("wrap_to_0", int'(sec_cnt), 0);

        // chain: 05:59 -> 06:00 on one edge
        set_in(0, 1, 59, 0, 1);
        min_ld = 1'b1; min_lv = 6'd5;
        step();
        set_in(0, 0, 0, 1, 1);
        step();
        chk("chain_sec", int'(sec_cnt), 0);
        chk("chain_min", int'(min_cnt), 6);

        // countdown 2,1,0,59
        set_in(0, 1, 2, 0, 1);
        step();
        set_in(0, 0, 0, 1, 0);
        repeat (3) step();
        chk("down_wrap", int'(sec_cnt), 59);

        // saturating stage held at 59, then steps down
        set_in(0, 1, 59, 0, 1);
        step();
        set_in(0, 0, 0, 1, 1);
        repeat (3) step();
        chk("sat_hold", int'(sat_cnt), 59);
        set_in(0, 0, 0, 1, 0);
        step();
        chk("sat_down", int'(sat_cnt), 58);

        // priority and clamp
        set_in(1, 1, 30, 1, 1);
        step();
        chk("clr_prio", int'(sec_cnt), 0);
        set_in(0, 1, 63, 0, 1);
        step();
        chk("clamp_cnt", int'(sec_cnt), 59);
        chk("clamp_err", int'(sec_le), 1);
        set_in(0, 0, 0, 0, 1);
        step();
        chk("err_pulse", int'(sec_le), 0);

        // asynchronous reset mid-cycle at 37
        set_in(0, 1, 37, 0, 1);
        step();
        set_in(0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cnt", int'(sec_cnt), 0);
        chk("async_bcd", int'(sec_bcd), 0);
        rst_n = 1'b1;
        m_sec = 0; m_min = 0; m_sat = 0; m_p2 = 0;
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 1, 1);
        repeat (12) step();
        chk("post_rst_cnt", int'(sec_cnt), 12);
        chk("post_rst_bcd", int'(sec_bcd), bcd(12));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 16) == 0, ($urandom % 8) == 0, int'($urandom % 64),
                   ($urandom % 4) != 0, 1'($urandom % 2));
            min_ld = ($urandom % 10) == 0;
            min_lv = 6'($urandom % 64);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
